// File: rtl/conv3x3_param.sv
// 3x3 convolution engine: runtime-loadable signed kernel (serial shadow load, atomic commit),
// three-stage multiply / accumulate / round-and-saturate pipeline with per-window shift and mode.
module conv3x3_param #(
   parameter int DATA_W  = 8,
   parameter int COEF_W  = 8,
   parameter int SHIFT_W = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [9*DATA_W-1:0]   i_pixel_data,
   input  logic                  i_pixel_data_valid,
   input  logic [SHIFT_W-1:0]    i_shift,
   input  logic [1:0]            i_mode,
   input  logic [COEF_W-1:0]     i_coef_data,
   input  logic                  i_coef_wr,
   input  logic                  i_coef_restart,
   output logic                  o_kernel_ready,
   output logic [DATA_W-1:0]     o_convolved_data,
   output logic                  o_convolved_data_valid,
   output logic                  o_sat
);

   localparam int ACC_W  = DATA_W + COEF_W + 5;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int RND_W  = ACC_W + 1;
   localparam logic signed [RND_W-1:0] PIX_MAX  = RND_W'((1 << DATA_W) - 1);
   localparam logic signed [RND_W-1:0] PIX_HALF = RND_W'(1 << (DATA_W - 1));

   localparam logic [1:0] MODE_CLAMP  = 2'd0;
   localparam logic [1:0] MODE_ABS    = 2'd1;
   localparam logic [1:0] MODE_OFFSET = 2'd2;

   // ---------------- coefficient load ----------------
   logic [COEF_W-1:0] shadow_q [9];
   logic [COEF_W-1:0] shadow_d [9];
   logic [COEF_W-1:0] coef_q   [9];
   logic [COEF_W-1:0] coef_d   [9];
   logic [3:0]        idx_q, idx_d;
   logic              ready_q;

   // Restart wins over a same-cycle write; the ninth write commits the whole shadow at once.
   always_comb begin
      shadow_d = shadow_q;
      coef_d   = coef_q;
      idx_d    = idx_q;
      if (i_coef_restart) begin
         idx_d = 4'd0;
      end else if (i_coef_wr) begin
         shadow_d[idx_q] = i_coef_data;
         if (idx_q == 4'd8) begin
            coef_d = shadow_d;
            idx_d  = 4'd0;
         end else begin
            idx_d = idx_q + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < 9; k++) begin
            shadow_q[k] <= '0;
            coef_q[k]   <= (k == 4) ? COEF_W'(1) : '0;
         end
         idx_q   <= 4'd0;
         ready_q <= 1'b1;
      end else begin
         shadow_q <= shadow_d;
         coef_q   <= coef_d;
         idx_q    <= idx_d;
         ready_q  <= (idx_d == 4'd0);
      end
   end

   assign o_kernel_ready = ready_q;

   // ---------------- stage 1: nine products ----------------
   logic signed [PROD_W-1:0] prod_d [9];
   logic signed [PROD_W-1:0] prod_q [9];
   logic [SHIFT_W-1:0]       sh1_q;
   logic [1:0]               md1_q;
   logic                     v1_q;

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         prod_d[k] = $signed({{(PROD_W-COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]}) *
                     $signed({{(PROD_W-DATA_W){1'b0}}, i_pixel_data[k*DATA_W +: DATA_W]});
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < 9; k++) prod_q[k] <= '0;
         sh1_q <= '0;
         md1_q <= '0;
         v1_q  <= 1'b0;
      end else begin
         v1_q <= i_pixel_data_valid;
         if (i_pixel_data_valid) begin
            prod_q <= prod_d;
            sh1_q  <= i_shift;
            md1_q  <= i_mode;
         end
      end
   end

   // ---------------- stage 2: accumulate ----------------
   logic signed [ACC_W-1:0] sum_d, sum_q;
   logic [SHIFT_W-1:0]      sh2_q;
   logic [1:0]              md2_q;
   logic                    v2_q;

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < 9; k++) begin
         sum_d = sum_d + $signed({{(ACC_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]});
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sum_q <= '0;
         sh2_q <= '0;
         md2_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            sum_q <= sum_d;
            sh2_q <= sh1_q;
            md2_q <= md1_q;
         end
      end
   end

   // ---------------- stage 3: round, mode, saturate ----------------
   function automatic logic [DATA_W:0] clip(input logic signed [RND_W-1:0] v);
      if (v[RND_W-1])   return {1'b1, {DATA_W{1'b0}}};
      else if (v > PIX_MAX) return {1'b1, {DATA_W{1'b1}}};
      else              return {1'b0, v[DATA_W-1:0]};
   endfunction

   logic signed [RND_W-1:0] sum_x, rnd_add, rnd, mag, off;
   logic [DATA_W-1:0]       res_d;
   logic                    sat_d;

   always_comb begin
      sum_x   = {sum_q[ACC_W-1], sum_q};
      rnd_add = '0;
      rnd     = sum_x;
      if (sh2_q != '0) begin
         rnd_add = RND_W'(1) << (sh2_q - SHIFT_W'(1));
         rnd     = (sum_x + rnd_add) >>> sh2_q;
      end
      mag = rnd[RND_W-1] ? -rnd : rnd;
      off = rnd + PIX_HALF;
      res_d = rnd[DATA_W-1:0];
      sat_d = 1'b0;
      case (md2_q)
         MODE_CLAMP:  {sat_d, res_d} = clip(rnd);
         MODE_ABS:    {sat_d, res_d} = clip(mag);
         MODE_OFFSET: {sat_d, res_d} = clip(off);
         default:     {sat_d, res_d} = {1'b0, rnd[DATA_W-1:0]};
      endcase
   end

   logic [DATA_W-1:0] data_q;
   logic              sat_q;
   logic              valid_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q  <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= v2_q;
         if (v2_q) begin
            data_q <= res_d;
            sat_q  <= sat_d;
         end
      end
   end

   assign o_convolved_data       = data_q;
   assign o_convolved_data_valid = valid_q;
   assign o_sat                  = sat_q;

endmodule

// File: tb/tb_conv3x3_param.sv
// Bench for conv3x3_param: scenario tasks driving windows and coefficient loads, with a
// reference model filling an expected queue that a negedge monitor drains.
module tb_conv3x3_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [71:0] i_pixel_data;
   logic        i_pixel_data_valid;
   logic [3:0]  i_shift;
   logic [1:0]  i_mode;
   logic [7:0]  i_coef_data;
   logic        i_coef_wr;
   logic        i_coef_restart;
   logic        o_kernel_ready;
   logic [7:0]  o_convolved_data;
   logic        o_convolved_data_valid;
   logic        o_sat;

   conv3x3_param #(.DATA_W(8), .COEF_W(8), .SHIFT_W(4)) dut (
      .i_clk                  (clk),
      .i_rst                  (rst),
      .i_pixel_data           (i_pixel_data),
      .i_pixel_data_valid     (i_pixel_data_valid),
      .i_shift                (i_shift),
      .i_mode                 (i_mode),
      .i_coef_data            (i_coef_data),
      .i_coef_wr              (i_coef_wr),
      .i_coef_restart         (i_coef_restart),
      .o_kernel_ready         (o_kernel_ready),
      .o_convolved_data       (o_convolved_data),
      .o_convolved_data_valid (o_convolved_data_valid),
      .o_sat                  (o_sat)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   int         tb_kern[9];
   int         tb_shadow[9];
   int         tb_idx;
   int         run_len = 0;
   int         max_run = 0;

   // ---------------- reference model ----------------
   function automatic logic [8:0] model(input logic [71:0] win, input int sh, input int md);
      int sum, r, a;
      sum = 0;
      for (int k = 0; k < 9; k++) sum += tb_kern[k] * int'(win[k*8 +: 8]);
      r = (sh == 0) ? sum : ((sum + (1 << (sh - 1))) >>> sh);
      case (md)
         0: a = r;
         1: a = (r < 0) ? -r : r;
         2: a = r + 128;
         default: return {1'b0, r[7:0]};
      endcase
      if (a < 0)   return {1'b1, 8'd0};
      if (a > 255) return {1'b1, 8'd255};
      return {1'b0, a[7:0]};
   endfunction

   function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      int a[9];
      logic [71:0] w;
      a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      for (int k = 0; k < 9; k++) w[k*8 +: 8] = a[k][7:0];
      return w;
   endfunction

   function automatic logic [71:0] rand_win();
      logic [71:0] w;
      for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      for (int k = 0; k < 9; k++) begin
         tb_kern[k]   = (k == 4) ? 1 : 0;
         tb_shadow[k] = 0;
      end
      tb_idx = 0;
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic vld, input logic [71:0] win, input int sh, input int md,
                        input logic wr, input logic [7:0] cd, input logic rs);
      i_pixel_data_valid = vld;
      i_pixel_data       = win;
      i_shift            = sh[3:0];
      i_mode             = md[1:0];
      i_coef_wr          = wr;
      i_coef_data        = cd;
      i_coef_restart     = rs;
      if (vld) exp_q.push_back(model(win, sh, md));
      if (rs) tb_idx = 0;
      else if (wr) begin
         tb_shadow[tb_idx] = int'($signed(cd));
         if (tb_idx == 8) begin
            tb_kern = tb_shadow;
            tb_idx  = 0;
         end else tb_idx++;
      end
      @(posedge clk);
      #1;
      i_pixel_data_valid = 1'b0;
      i_coef_wr          = 1'b0;
      i_coef_restart     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_kernel(input logic [71:0] kv);
      for (int k = 0; k < 9; k++) drive(1'b0, '0, 0, 0, 1'b1, kv[k*8 +: 8], 1'b0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst) run_len = 0;
      else if (o_convolved_data_valid) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_unexpected got data=%0d sat=%0d required no output",
                     o_convolved_data, o_sat);
         end else begin
            mon_e = exp_q.pop_front();
            if ({o_sat, o_convolved_data} !== mon_e) begin
               bad++;
               $display("FAIL scoreboard got data=%0d sat=%0d required data=%0d sat=%0d",
                        o_convolved_data, o_sat, mon_e[7:0], mon_e[8]);
            end
         end
      end else run_len = 0;
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      total++;
      if (o_convolved_data_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b required=0", o_convolved_data_valid);
      end
      total++;
      if (o_convolved_data !== 8'd0) begin
         bad++; $display("FAIL reset_data got=%0d required=0", o_convolved_data);
      end
      total++;
      if (o_sat !== 1'b0) begin
         bad++; $display("FAIL reset_sat got=%b required=0", o_sat);
      end
      total++;
      if (o_kernel_ready !== 1'b1) begin
         bad++; $display("FAIL reset_ready got=%b required=1", o_kernel_ready);
      end
   endtask

   task automatic test_identity_latency();
      int lat;
      drive(1'b1, pack9(0, 10, 20, 30, 40, 50, 60, 70, 80), 0, 0, 1'b0, 8'd0, 1'b0);
      lat = 1;
      while (!o_convolved_data_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      total++;
      if (lat != 3) begin
         bad++; $display("FAIL latency got=%0d required=3", lat);
      end
      total++;
      if (o_convolved_data !== 8'd40 || o_sat !== 1'b0) begin
         bad++; $display("FAIL identity got data=%0d sat=%b required data=40 sat=0",
                         o_convolved_data, o_sat);
      end
      idle(4);
   endtask

   task automatic test_laplacian();
      load_kernel(pack9(-1, -1, -1, -1, 8, -1, -1, -1, -1));
      drive(1'b1, pack9(100, 100, 100, 100, 100, 100, 100, 100, 100), 0, 0, 1'b0, 8'd0, 1'b0);
      drive(1'b1, pack9(100, 100, 100, 100, 200, 100, 100, 100, 100), 0, 0, 1'b0, 8'd0, 1'b0);
      drive(1'b1, pack9(100, 100, 100, 100, 0, 100, 100, 100, 100), 0, 1, 1'b0, 8'd0, 1'b0);
      drive(1'b1, pack9(100, 100, 100, 100, 200, 100, 100, 100, 100), 0, 3, 1'b0, 8'd0, 1'b0);
      idle(6);
      total++;
      if (o_convolved_data !== 8'd32 || o_sat !== 1'b0) begin
         bad++; $display("FAIL laplacian_raw got data=%0d sat=%b required data=32 sat=0",
                         o_convolved_data, o_sat);
      end
   endtask

   task automatic test_gaussian();
      load_kernel(pack9(1, 2, 1, 2, 4, 2, 1, 2, 1));
      drive(1'b1, pack9(255, 255, 255, 255, 255, 255, 255, 255, 255), 4, 0, 1'b0, 8'd0, 1'b0);
      drive(1'b1, pack9(7, 7, 7, 7, 7, 7, 7, 7, 7), 4, 0, 1'b0, 8'd0, 1'b0);
      drive(1'b1, pack9(0, 0, 0, 0, 9, 0, 0, 0, 0), 4, 0, 1'b0, 8'd0, 1'b0);
      idle(6);
      total++;
      if (o_convolved_data !== 8'd2 || o_sat !== 1'b0) begin
         bad++; $display("FAIL gaussian_round got data=%0d sat=%b required data=2 sat=0",
                         o_convolved_data, o_sat);
      end
   endtask

   task automatic test_sobel_offset();
      load_kernel(pack9(-1, 0, 1, -2, 0, 2, -1, 0, 1));
      drive(1'b1, pack9(0, 128, 255, 0, 128, 255, 0, 128, 255), 0, 2, 1'b0, 8'd0, 1'b0);
      idle(5);
      total++;
      if (o_convolved_data !== 8'd255 || o_sat !== 1'b1) begin
         bad++; $display("FAIL sobel_clip got data=%0d sat=%b required data=255 sat=1",
                         o_convolved_data, o_sat);
      end
      drive(1'b1, pack9(50, 50, 50, 50, 50, 50, 50, 50, 50), 0, 2, 1'b0, 8'd0, 1'b0);
      idle(5);
      total++;
      if (o_convolved_data !== 8'd128 || o_sat !== 1'b0) begin
         bad++; $display("FAIL sobel_flat got data=%0d sat=%b required data=128 sat=0",
                         o_convolved_data, o_sat);
      end
   endtask

   task automatic test_back_to_back();
      max_run = 0;
      for (int i = 0; i < 24; i++) begin
         drive(1'b1, rand_win(), $urandom_range(0, 15), $urandom_range(0, 3),
               (i >= 5 && i < 14), 8'($urandom_range(0, 255)), 1'b0);
      end
      idle(6);
      total++;
      if (max_run < 24) begin
         bad++; $display("FAIL stream_run got=%0d required=24", max_run);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL stream_drain got=%0d pending required=0", exp_q.size());
      end
   endtask

   task automatic test_restart_reset();
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 0, 0, 1'b1, 8'd50, 1'b0);
      total++;
      if (o_kernel_ready !== 1'b0) begin
         bad++; $display("FAIL partial_ready got=%b required=0", o_kernel_ready);
      end
      drive(1'b0, '0, 0, 0, 1'b1, 8'd77, 1'b1);
      total++;
      if (o_kernel_ready !== 1'b1) begin
         bad++; $display("FAIL restart_ready got=%b required=1", o_kernel_ready);
      end
      load_kernel(pack9(1, 1, 1, 1, 1, 1, 1, 1, 1));
      total++;
      if (o_kernel_ready !== 1'b1) begin
         bad++; $display("FAIL commit_ready got=%b required=1", o_kernel_ready);
      end
      drive(1'b1, pack9(8, 8, 8, 8, 8, 8, 8, 8, 8), 3, 0, 1'b0, 8'd0, 1'b0);
      drive(1'b1, rand_win(), 5, 0, 1'b0, 8'd0, 1'b0);
      idle(6);
      // reset mid-stream with a partial load pending
      for (int i = 0; i < 4; i++) drive(1'b1, rand_win(), 0, 0, 1'b1, 8'd3, 1'b0);
      rst = 1'b1;
      model_reset();
      #2;
      total++;
      if (o_convolved_data_valid !== 1'b0 || o_convolved_data !== 8'd0 || o_kernel_ready !== 1'b1) begin
         bad++; $display("FAIL midreset got valid=%b data=%0d ready=%b required valid=0 data=0 ready=1",
                         o_convolved_data_valid, o_convolved_data, o_kernel_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, pack9(0, 10, 20, 30, 40, 50, 60, 70, 80), 0, 0, 1'b0, 8'd0, 1'b0);
      idle(6);
      total++;
      if (o_convolved_data !== 8'd40 || exp_q.size() != 0) begin
         bad++; $display("FAIL post_reset_identity got data=%0d pending=%0d required data=40 pending=0",
                         o_convolved_data, exp_q.size());
      end
   endtask

   initial begin
      rst                = 1'b1;
      i_pixel_data       = '0;
      i_pixel_data_valid = 1'b0;
      i_shift            = '0;
      i_mode             = '0;
      i_coef_data        = '0;
      i_coef_wr          = 1'b0;
      i_coef_restart     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_identity_latency();
      test_laplacian();
      test_gaussian();
      test_sobel_offset();
      test_back_to_back();
      test_restart_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
